arf_err_stats: RTL and testbench
================================

# arf_err_stats

Hardware error-statistics accumulator that sits directly downstream of the paired `arf_variance` / `arf_accurate` datapaths. Each accepted sample carries both outputs (27 and 28) of both implementations. For each output channel the block forms the signed error `var - acc`, then accumulates the error sum and the sum of squares over a run of 2^LOG2_N samples. At the end of the run it produces the mean and variance, which lets long approximate-vs-accurate error characterisation runs happen on FPGA instead of in simulation.

## Interface
Parameters:
- DATA_W, 32, width of each ARF output word (treated as signed)
- LOG2_N, 10, log2 of the samples per run; N = 2^LOG2_N, legal range 1..20

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE or DONE
- in_valid  in  1  sample present on the out_* inputs
- in_ready  out  1  block accepts a sample this cycle
- out_27_var, out_27_acc, out_28_var, out_28_acc  in  DATA_W each  ARF outputs for channels 27 and 28
- busy  out  1  a run is in progress (not IDLE/DONE)
- done  out  1  one-cycle pulse when results update
- sum_27, sum_28  out  DATA_W+1+LOG2_N  signed error sum
- sumsq_27, sumsq_28  out  2*(DATA_W+1)+LOG2_N  unsigned sum of squared errors
- mean_27, mean_28  out  DATA_W+1  signed, sum >>> LOG2_N (floor)
- var_27, var_28  out  2*(DATA_W+1)  unsigned variance
- maxabs_27, maxabs_28  out  DATA_W+1  unsigned maximum |error| (see Configuration)

## Operation
- FSM states: IDLE, ACCUM, DRAIN, FINAL, DONE.
  - IDLE → ACCUM on start: clears the accumulators and the sample counter.
  - ACCUM → DRAIN when the N-th sample is accepted.
  - DRAIN lasts 2 cycles to flush the pipeline, then → FINAL.
  - FINAL lasts 1 cycle, then → DONE.
  - DONE → ACCUM on start; otherwise DONE holds.
- Accept condition: in_valid && in_ready. in_ready = (state == ACCUM).
- Error: e = $signed(var) - $signed(acc), computed at DATA_W+1 bits. It never wraps; the extremes are ±(2^DATA_W - 1).
- Pipeline per channel:
  - stage 1 registers e;
  - stage 2 adds e into sum and e*e into sumsq.
- FINAL computes var = (sumsq >> LOG2_N) - ((sum*sum) >> (2*LOG2_N)). The result is always ≥ 0.
- Result outputs (sum, sumsq, mean, var, maxabs) update only in FINAL. They hold their values through DONE and through the whole next run, until the next FINAL.
- start while busy is ignored. start in the same cycle as reset is ignored.
- in_valid gaps during ACCUM only stall the counter.

## Timing
- Reset values: in_ready=0, busy=0, done=0, and every result output is 0. FSM → IDLE, counter and accumulators cleared.
- A sample accepted at cycle t appears in the accumulators at t+2.
- Last accept at cycle t: DRAIN covers t+1..t+2, FINAL is t+3, results are valid and done=1 at t+4 (DONE state).
- Minimum run length is N + 4 cycles after the start cycle.
- Reset mid-run aborts the run. Results return to 0 and no done pulse is produced.

## Configuration
- ARF_ERR_MAXABS_EN defined: each channel tracks the maximum |e| over the run. The tracker is updated in stage 2, cleared on start, and published in FINAL.
- ARF_ERR_MAXABS_EN undefined: no tracker logic is built, and maxabs_27 / maxabs_28 are constant 0.

## Structure
- Package `arf_stats_pkg` holds:
  - the FSM state enum `arf_stats_state_t`;
  - width helper constants (ERR_W = DATA_W+1, SUM_W, SQ_W);
  - the DRAIN length constant (2).
- Sub-module `arf_err_chan` covers one channel: the error register, the square, the sum/sumsq accumulators, optional maxabs, and the FINAL variance math. The top level instantiates it twice and owns the FSM and counter.

## Test plan
All scenarios use LOG2_N=2 (N=4) unless stated.
- Identical var/acc inputs for 4 samples → sum=0, sumsq=0, mean=0, var=0, one done pulse 4 cycles after the last accept.
- ch27 errors +1,+1,+1,+1 → sum=4, sumsq=4, mean=1, var=0.
- ch28 errors +2,-2,+2,-2 → sum=0, sumsq=16, mean=0, var=4.
- Simultaneous ch27 errors -3 ×4 → sum=-12, mean=-3, var=0, maxabs=3 (with the macro) or 0 (without).
- var=0x7FFFFFFF, acc=0x80000000 for 4 samples → e=4294967295 with no wrap, and sumsq = 4·(2^32-1)^2.
- Protocol scenario:
  - random in_valid gaps still give the same results;
  - start during ACCUM is ignored;
  - rst asserted after 2 accepts → all outputs 0, busy=0, no done pulse;
  - a fresh start then completes normally.

Source files
------------

// File: rtl/arf_err_stats_pkg.sv
// Shared FSM state type, width helpers and drain length for the ARF error-statistics block.
package arf_stats_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_FINAL,
    ST_DONE
  } arf_stats_state_t;

  // Cycles spent flushing the two-stage channel pipeline after the last sample.
  localparam int DRAIN_CYCLES = 2;

  function automatic int arf_err_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int arf_sum_w(input int data_w, input int log2_n);
    return data_w + 1 + log2_n;
  endfunction

  function automatic int arf_sq_w(input int data_w, input int log2_n);
    return 2 * (data_w + 1) + log2_n;
  endfunction

endpackage

// File: rtl/arf_err_stats_if.sv
// Sample bus carrying both ARF implementations' outputs with a valid/ready handshake.
interface arf_err_stats_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_27_var;
  logic [DATA_W-1:0] out_27_acc;
  logic [DATA_W-1:0] out_28_var;
  logic [DATA_W-1:0] out_28_acc;

  modport master (output in_valid, out_27_var, out_27_acc, out_28_var, out_28_acc,
                  input  in_ready);
  modport slave  (input  in_valid, out_27_var, out_27_acc, out_28_var, out_28_acc,
                  output in_ready);
endinterface

// File: rtl/arf_err_chan.sv
// One error channel: e = var - acc, sum / sum-of-squares accumulators, mean/variance on final_en.
// Sample reaches the accumulators 2 cycles after accept; no backpressure. Max |e| only with ARF_ERR_MAXABS_EN.
module arf_err_chan
  import arf_stats_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LOG2_N = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              smp_vld,
  input  logic [DATA_W-1:0]                 var_dat,
  input  logic [DATA_W-1:0]                 acc_dat,
  input  logic                              final_en,
  output logic signed [DATA_W+LOG2_N:0]     sum_o,
  output logic [2*DATA_W+LOG2_N+1:0]        sumsq_o,
  output logic signed [DATA_W:0]            mean_o,
  output logic [2*DATA_W+1:0]               var_o,
  output logic [DATA_W:0]                   maxabs_o
);
  localparam int ERR_W = arf_err_w(DATA_W);
  localparam int SUM_W = arf_sum_w(DATA_W, LOG2_N);
  localparam int SQ_W  = arf_sq_w(DATA_W, LOG2_N);
  localparam int VAR_W = 2 * ERR_W;
  localparam int MUL_W = 2 * SUM_W;

  logic signed [ERR_W-1:0] err_q, err_d;
  logic                    err_vld_q, err_vld_d;
  logic [ERR_W-1:0]        abs_e;
  logic [VAR_W-1:0]        abs_ext, sq;
  logic signed [SUM_W-1:0] acc_sum_q, acc_sum_d;
  logic [SQ_W-1:0]         acc_sq_q, acc_sq_d;
  logic [MUL_W-1:0]        sum_ext, sum_sqr, mean_sq, sq_mean;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [SQ_W-1:0]         sumsq_q, sumsq_d;
  logic signed [ERR_W-1:0] mean_q, mean_d;
  logic [VAR_W-1:0]        var_q, var_d;

  always_comb begin
    // One extra bit keeps var - acc exact for any pair of signed inputs.
    err_d     = $signed({var_dat[DATA_W-1], var_dat}) - $signed({acc_dat[DATA_W-1], acc_dat});
    err_vld_d = smp_vld;
    abs_e     = err_q[ERR_W-1] ? -err_q : err_q;
    abs_ext   = {{(VAR_W-ERR_W){1'b0}}, abs_e};
    sq        = abs_ext * abs_ext;

    acc_sum_d = acc_sum_q;
    acc_sq_d  = acc_sq_q;
    if (clr) begin
      acc_sum_d = '0;
      acc_sq_d  = '0;
    end else if (err_vld_q) begin
      acc_sum_d = acc_sum_q + {{(SUM_W-ERR_W){err_q[ERR_W-1]}}, err_q};
      acc_sq_d  = acc_sq_q + {{(SQ_W-VAR_W){1'b0}}, sq};
    end

    sum_ext = {{(MUL_W-SUM_W){acc_sum_q[SUM_W-1]}}, acc_sum_q};
    sum_sqr = sum_ext * sum_ext;
    mean_sq = sum_sqr >> (2 * LOG2_N);
    sq_mean = {{(MUL_W-SQ_W){1'b0}}, acc_sq_q} >> LOG2_N;

    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    mean_d  = mean_q;
    var_d   = var_q;
    if (final_en) begin
      sum_d   = acc_sum_q;
      sumsq_d = acc_sq_q;
      mean_d  = ERR_W'(acc_sum_q >>> LOG2_N);
      var_d   = VAR_W'(sq_mean - mean_sq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= '0;
      err_vld_q <= 1'b0;
      acc_sum_q <= '0;
      acc_sq_q  <= '0;
      sum_q     <= '0;
      sumsq_q   <= '0;
      mean_q    <= '0;
      var_q     <= '0;
    end else begin
      err_q     <= err_d;
      err_vld_q <= err_vld_d;
      acc_sum_q <= acc_sum_d;
      acc_sq_q  <= acc_sq_d;
      sum_q     <= sum_d;
      sumsq_q   <= sumsq_d;
      mean_q    <= mean_d;
      var_q     <= var_d;
    end
  end

  assign sum_o   = sum_q;
  assign sumsq_o = sumsq_q;
  assign mean_o  = mean_q;
  assign var_o   = var_q;

`ifdef ARF_ERR_MAXABS_EN
  logic [ERR_W-1:0] max_q, max_d;
  logic [ERR_W-1:0] maxabs_q, maxabs_d;

  always_comb begin
    max_d = max_q;
    if (clr) begin
      max_d = '0;
    end else if (err_vld_q && (abs_e > max_q)) begin
      max_d = abs_e;
    end
    maxabs_d = final_en ? max_q : maxabs_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q    <= '0;
      maxabs_q <= '0;
    end else begin
      max_q    <= max_d;
      maxabs_q <= maxabs_d;
    end
  end

  assign maxabs_o = maxabs_q;
`else
  assign maxabs_o = '0;
`endif

endmodule

// File: rtl/arf_err_stats.sv
// Accumulates var-acc error sum, sum of squares, mean and variance over 2^LOG2_N samples for ARF channels 27/28.
// Results land 4 cycles after the last accept; in_ready only in ACCUM. Optional max |e| via ARF_ERR_MAXABS_EN.
module arf_err_stats
  import arf_stats_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LOG2_N = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  arf_err_stats_if.slave                smp,
  output logic                          busy,
  output logic                          done,
  output logic signed [DATA_W+LOG2_N:0] sum_27,
  output logic signed [DATA_W+LOG2_N:0] sum_28,
  output logic [2*DATA_W+LOG2_N+1:0]    sumsq_27,
  output logic [2*DATA_W+LOG2_N+1:0]    sumsq_28,
  output logic signed [DATA_W:0]        mean_27,
  output logic signed [DATA_W:0]        mean_28,
  output logic [2*DATA_W+1:0]           var_27,
  output logic [2*DATA_W+1:0]           var_28,
  output logic [DATA_W:0]               maxabs_27,
  output logic [DATA_W:0]               maxabs_28
);
  localparam logic [LOG2_N-1:0] CNT_LAST   = '1;
  localparam logic [1:0]        DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  arf_stats_state_t  state_q, state_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [1:0]        drain_q, drain_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, run_clr, final_en;

  assign accept   = smp.in_valid && rdy_q;
  assign final_en = (state_q == ST_FINAL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    run_clr = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
          run_clr = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + LOG2_N'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == DRAIN_LAST) state_d = ST_FINAL;
      end
      ST_FINAL: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    rdy_d  = (state_d == ST_ACCUM);
    busy_d = (state_d == ST_ACCUM) || (state_d == ST_DRAIN) || (state_d == ST_FINAL);
    done_d = (state_q == ST_FINAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign smp.in_ready = rdy_q;
  assign busy         = busy_q;
  assign done         = done_q;

  arf_err_chan #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_chan_27 (
    .clk      (clk),
    .rst      (rst),
    .clr      (run_clr),
    .smp_vld  (accept),
    .var_dat  (smp.out_27_var),
    .acc_dat  (smp.out_27_acc),
    .final_en (final_en),
    .sum_o    (sum_27),
    .sumsq_o  (sumsq_27),
    .mean_o   (mean_27),
    .var_o    (var_27),
    .maxabs_o (maxabs_27)
  );

  arf_err_chan #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_chan_28 (
    .clk      (clk),
    .rst      (rst),
    .clr      (run_clr),
    .smp_vld  (accept),
    .var_dat  (smp.out_28_var),
    .acc_dat  (smp.out_28_acc),
    .final_en (final_en),
    .sum_o    (sum_28),
    .sumsq_o  (sumsq_28),
    .mean_o   (mean_28),
    .var_o    (var_28),
    .maxabs_o (maxabs_28)
  );

endmodule

// File: tb/tb_arf_err_stats.sv
// Randomized self-checking bench for arf_err_stats with N=4, against an arithmetic reference model.
module tb_arf_err_stats;
  localparam int DATA_W = 32;
  localparam int LOG2_N = 2;
  localparam int N      = 4;

  logic clk, rst, start;
  logic busy, done;
  logic signed [DATA_W+LOG2_N:0] sum_27, sum_28;
  logic [2*DATA_W+LOG2_N+1:0]    sumsq_27, sumsq_28;
  logic signed [DATA_W:0]        mean_27, mean_28;
  logic [2*DATA_W+1:0]           var_27, var_28;
  logic [DATA_W:0]               maxabs_27, maxabs_28;

  arf_err_stats_if #(.DATA_W(DATA_W)) smp ();

  arf_err_stats #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .smp       (smp),
    .busy      (busy),
    .done      (done),
    .sum_27    (sum_27),
    .sum_28    (sum_28),
    .sumsq_27  (sumsq_27),
    .sumsq_28  (sumsq_28),
    .mean_27   (mean_27),
    .mean_28   (mean_28),
    .var_27    (var_27),
    .var_28    (var_28),
    .maxabs_27 (maxabs_27),
    .maxabs_28 (maxabs_28)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] v27 [N];
  logic [31:0] a27 [N];
  logic [31:0] v28 [N];
  logic [31:0] a28 [N];

  logic signed [127:0] exp_sum  [2];
  logic signed [127:0] exp_sq   [2];
  logic signed [127:0] exp_mean [2];
  logic signed [127:0] exp_var  [2];
  logic signed [127:0] exp_max  [2];
  logic signed [127:0] hold_sum27, hold_var28;

  task automatic chk(input string tag, input logic signed [127:0] got, input logic signed [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic gen(input int mode);
    for (int i = 0; i < N; i++) begin
      v27[i] = $urandom; a27[i] = $urandom;
      v28[i] = $urandom; a28[i] = $urandom;
      case (mode)
        0: begin a27[i] = v27[i]; a28[i] = v28[i]; end
        1: begin a27[i] = $urandom_range(0, 100000); v27[i] = a27[i] + 32'd1; a28[i] = v28[i]; end
        2: begin
          a27[i] = v27[i];
          a28[i] = $urandom_range(10, 100000);
          v28[i] = (i % 2 == 0) ? a28[i] + 32'd2 : a28[i] - 32'd2;
        end
        3: begin a27[i] = $urandom_range(10, 100000); v27[i] = a27[i] - 32'd3; end
        4: begin
          v27[i] = 32'h7FFF_FFFF; a27[i] = 32'h8000_0000;
          v28[i] = 32'h7FFF_FFFF; a28[i] = 32'h8000_0000;
        end
        default: ;
      endcase
    end
  endtask

  // Reference: exact integer statistics with floor division by N and N^2.
  task automatic model();
    for (int ch = 0; ch < 2; ch++) begin
      logic signed [127:0] s, sq, mx, e, q;
      longint x, y;
      s = 0; sq = 0; mx = 0;
      for (int i = 0; i < N; i++) begin
        x  = (ch == 0) ? longint'($signed(v27[i])) : longint'($signed(v28[i]));
        y  = (ch == 0) ? longint'($signed(a27[i])) : longint'($signed(a28[i]));
        e  = x - y;
        s  = s + e;
        sq = sq + e * e;
        if (e < 0) e = -e;
        if (e > mx) mx = e;
      end
      q = s / N;
      if (s < 0 && (s % N) != 0) q = q - 1;
      exp_sum[ch]  = s;
      exp_sq[ch]   = sq;
      exp_mean[ch] = q;
      exp_var[ch]  = sq / N - (s * s) / (N * N);
`ifdef ARF_ERR_MAXABS_EN
      exp_max[ch]  = mx;
`else
      exp_max[ch]  = 0;
`endif
    end
  endtask

  task automatic check_results(input string pfx);
    chk({pfx, "_sum27"},   sum_27,    exp_sum[0]);
    chk({pfx, "_sum28"},   sum_28,    exp_sum[1]);
    chk({pfx, "_sumsq27"}, sumsq_27,  exp_sq[0]);
    chk({pfx, "_sumsq28"}, sumsq_28,  exp_sq[1]);
    chk({pfx, "_mean27"},  mean_27,   exp_mean[0]);
    chk({pfx, "_mean28"},  mean_28,   exp_mean[1]);
    chk({pfx, "_var27"},   var_27,    exp_var[0]);
    chk({pfx, "_var28"},   var_28,    exp_var[1]);
    chk({pfx, "_max27"},   maxabs_27, exp_max[0]);
    chk({pfx, "_max28"},   maxabs_28, exp_max[1]);
  endtask

  // inject: 0 plain run, 1 start pulse mid-ACCUM, 2 reset after two accepts
  task automatic do_run(input string pfx, input bit gaps, input int inject);
    int  i, guard, lat, ndone;
    bit  acc_now, poked;
    i = 0; guard = 0; poked = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({pfx, "_busy_run"}, busy, 1);
    while (i < N && guard < 200) begin
      guard++;
      if (inject == 1 && i == 2 && !poked) begin
        poked = 1; smp.in_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({pfx, "_hold_sum27"}, sum_27, hold_sum27);
        chk({pfx, "_hold_var28"}, var_28, hold_var28);
        chk({pfx, "_busy_accum"}, busy, 1);
        continue;
      end
      if (inject == 2 && i == 2) begin
        smp.in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk({pfx, "_abort_busy"},  busy, 0);
        chk({pfx, "_abort_rdy"},   smp.in_ready, 0);
        chk({pfx, "_abort_sum27"}, sum_27, 0);
        chk({pfx, "_abort_sq28"},  sumsq_28, 0);
        chk({pfx, "_abort_mean27"}, mean_27, 0);
        chk({pfx, "_abort_var28"}, var_28, 0);
        ndone = 0;
        repeat (10) begin
          @(negedge clk);
          if (done) ndone++;
        end
        chk({pfx, "_abort_done"}, ndone, 0);
        return;
      end
      smp.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (smp.in_valid) begin
        smp.out_27_var = v27[i]; smp.out_27_acc = a27[i];
        smp.out_28_var = v28[i]; smp.out_28_acc = a28[i];
      end else begin
        smp.out_27_var = $urandom; smp.out_27_acc = $urandom;
        smp.out_28_var = $urandom; smp.out_28_acc = $urandom;
      end
      acc_now = smp.in_valid && smp.in_ready;
      @(negedge clk);
      if (acc_now) i++;
    end
    smp.in_valid = 1'b0;
    chk({pfx, "_accepts"}, i, N);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({pfx, "_done_lat"}, lat, 4);
    check_results(pfx);
    @(negedge clk);
    chk({pfx, "_done_pulse"}, done, 0);
    chk({pfx, "_busy_done"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    smp.in_valid = 1'b0;
    smp.out_27_var = '0; smp.out_27_acc = '0;
    smp.out_28_var = '0; smp.out_28_acc = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy",    smp.in_ready, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_sum27",  sum_27, 0);
    chk("rst_sq28",   sumsq_28, 0);
    chk("rst_var27",  var_27, 0);
    chk("rst_max28",  maxabs_28, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    gen(0); model(); do_run("ident", 0, 0);
    gen(1); model(); do_run("plus1", 0, 0);
    gen(2); model(); do_run("alt2", 0, 0);
    gen(3); model(); do_run("neg3", 0, 0);
    gen(4); model(); do_run("extreme", 0, 0);
    chk("extreme_sumsq_const", sumsq_27, 128'h3FFFFFFF800000004);
    for (int r = 0; r < 4; r++) begin
      gen(5); model(); do_run("rand", 0, 0);
    end

    gen(5); model(); do_run("gaps", 1, 0);
    hold_sum27 = exp_sum[0]; hold_var28 = exp_var[1];
    gen(5); model(); do_run("startign", 1, 1);
    gen(5); do_run("abort", 0, 2);

    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rststart_busy", busy, 0);
    chk("rststart_rdy",  smp.in_ready, 0);

    gen(5); model(); do_run("fresh", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
